// File: rtl/pc_stall_ctrl.sv
// pc_stall_ctrl: next-PC selection and F/D stall control for the 5-stage core.
// It owns the mult/div busy countdown and a free-running count of stall cycles.
//
// Handshake: there is no valid/ready pair here. Each cycle the controller
// looks at the hazard inputs and either lets F/D advance or holds them.
// - Advance: f_pc_en=1, d_reg_en=1, e_reg_clr=0.
// - Stall:   f_pc_en=0, d_reg_en=0, e_reg_clr=1, so a bubble enters E.
// Control transfers resolve in D and have a delay slot, so F is never
// flushed. A stalled cycle drops npc_sel's effect because f_pc_en is low.
module pc_stall_ctrl #(
  parameter logic [31:0] INIT_ADDR   = 32'h0000_3000,
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_pc,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_val,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic [4:0]  e_waddr,
  input  logic [4:0]  m_waddr,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        d_md_use,
  input  logic        e_md_start,
  input  logic        e_md_div,
  output logic [31:0] f_npc,
  output logic        f_pc_en,
  output logic        d_reg_en,
  output logic        e_reg_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_J   = 2'd2;
  localparam logic [1:0] SEL_JR  = 2'd3;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  r_md_cnt;
  logic [31:0] r_stall_cnt;

  logic [31:0] w_seq_pc;
  logic [31:0] w_br_pc;
  logic        w_rs_stall;
  logic        w_rt_stall;
  logic        w_data_stall;
  logic        w_md_busy;
  logic        w_md_stall;
  logic        w_stall;

  assign w_seq_pc = f_pc + 32'd4;
  assign w_br_pc  = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};

  // Next-PC mux. While reset is held the PC register is enabled, so it is
  // fed INIT_ADDR and comes out of reset pointing at the boot vector.
  always_comb begin
    f_npc = w_seq_pc;
    if (reset) begin
      f_npc = INIT_ADDR;
    end else begin
      case (npc_sel)
        SEL_SEQ: f_npc = w_seq_pc;
        SEL_BR:  f_npc = br_taken ? w_br_pc : w_seq_pc;
        SEL_J:   f_npc = {d_pc[31:28], d_imm26, 2'b00};
        SEL_JR:  f_npc = d_rs_val;
        default: f_npc = w_seq_pc;
      endcase
    end
  end

  // Tuse/Tnew hazard detection; register 0 is hardwired and never waits.
  always_comb begin
    w_rs_stall = (d_rs != 5'd0) &&
                 (((d_rs == e_waddr) && (e_tnew > d_rs_tuse)) ||
                  ((d_rs == m_waddr) && (m_tnew > d_rs_tuse)));
    w_rt_stall = (d_rt != 5'd0) &&
                 (((d_rt == e_waddr) && (e_tnew > d_rt_tuse)) ||
                  ((d_rt == m_waddr) && (m_tnew > d_rt_tuse)));
    w_data_stall = w_rs_stall | w_rt_stall;
  end

  assign w_md_busy  = (r_md_cnt != 4'd0) | e_md_start;
  assign w_md_stall = d_md_use & w_md_busy;
  assign w_stall    = w_data_stall | w_md_stall;

  // Pipeline enables; reset forces everything to load and flushes D/E.
  always_comb begin
    f_pc_en   = 1'b1;
    d_reg_en  = 1'b1;
    e_reg_clr = 1'b0;
    if (reset) begin
      e_reg_clr = 1'b1;
    end else if (w_stall) begin
      f_pc_en   = 1'b0;
      d_reg_en  = 1'b0;
      e_reg_clr = 1'b1;
    end
  end

  // Mult/div busy countdown; a new start reloads rather than queueing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= 4'd0;
    end else if (e_md_start) begin
      r_md_cnt <= e_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (r_md_cnt != 4'd0) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

  // Stall cycle counter; a cycle with both hazard kinds counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign md_busy   = w_md_busy;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Bench for pc_stall_ctrl: directed vectors with hand-computed expectations
// pushed into a queue by the driver and checked by a negedge monitor.
module tb_pc_stall_ctrl;

  localparam int W = 68;  // {npc[31:0], pc_en, d_en, clr, busy, cnt[31:0]}

  logic        clk;
  logic        reset;
  logic [31:0] f_pc;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs_val;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_rs_tuse;
  logic [1:0]  d_rt_tuse;
  logic [4:0]  e_waddr;
  logic [4:0]  m_waddr;
  logic [1:0]  e_tnew;
  logic [1:0]  m_tnew;
  logic        d_md_use;
  logic        e_md_start;
  logic        e_md_div;
  logic [31:0] f_npc;
  logic        f_pc_en;
  logic        d_reg_en;
  logic        e_reg_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           checks;
  int           errors;
  int           vec_id;
  logic [31:0]  exp_cnt;

  pc_stall_ctrl dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .d_pc(d_pc), .d_imm16(d_imm16),
    .d_imm26(d_imm26), .d_rs_val(d_rs_val), .npc_sel(npc_sel), .br_taken(br_taken),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .e_waddr(e_waddr), .m_waddr(m_waddr), .e_tnew(e_tnew), .m_tnew(m_tnew),
    .d_md_use(d_md_use), .e_md_start(e_md_start), .e_md_div(e_md_div),
    .f_npc(f_npc), .f_pc_en(f_pc_en), .d_reg_en(d_reg_en), .e_reg_clr(e_reg_clr),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Clock / reset block: clk starts high so each driven cycle is checked
  // on the following negedge before the next active edge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Monitor: pop one expectation per cycle and compare all outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      int           t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {f_npc, f_pc_en, d_reg_en, e_reg_clr, md_busy, stall_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL vec%0d: got npc=%h en=%b den=%b clr=%b busy=%b cnt=%0d, want npc=%h en=%b den=%b clr=%b busy=%b cnt=%0d",
                 t, a[67:36], a[35], a[34], a[33], a[32], a[31:0],
                 e[67:36], e[35], e[34], e[33], e[32], e[31:0]);
      end
    end
  end

  // Driver: return all inputs to a quiet, hazard-free state.
  task automatic idle();
    f_pc = 32'h0000_3000; d_pc = 32'h0000_2FFC; d_imm16 = 16'h0; d_imm26 = 26'h0;
    d_rs_val = 32'h0; npc_sel = 2'd0; br_taken = 1'b0;
    d_rs = 5'd0; d_rt = 5'd0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
    e_waddr = 5'd0; m_waddr = 5'd0; e_tnew = 2'd0; m_tnew = 2'd0;
    d_md_use = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
  endtask

  // Driver: push the hand-computed expectation for the current inputs, then
  // advance one cycle. stall is the hand-derived stall decision.
  task automatic expect_cycle(input logic [31:0] npc, input logic stall, input logic busy);
    logic en;
    logic clr;
    en  = reset ? 1'b1 : ~stall;
    clr = reset ? 1'b1 : stall;
    exp_q.push_back({npc, en, en, clr, busy, exp_cnt});
    tag_q.push_back(vec_id);
    vec_id++;
    if (reset) exp_cnt = 32'd0;
    else if (stall) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0; vec_id = 0; exp_cnt = 32'd0;
    idle();
    // Reset: first cycle unchecked (counters still unknown), then checked.
    reset = 1'b1;
    @(posedge clk); #1;
    expect_cycle(32'h0000_3000, 1'b0, 1'b0);
    reset = 1'b0;

    // 1. idle sequential fetch
    for (int i = 0; i < 3; i++) expect_cycle(32'h0000_3004, 1'b0, 1'b0);

    // 2. load-use on rs, then resolved via M
    e_waddr = 5'd5; e_tnew = 2'd2; d_rs = 5'd5; d_rs_tuse = 2'd1;
    expect_cycle(32'h0000_3004, 1'b1, 1'b0);
    e_waddr = 5'd0; e_tnew = 2'd0; m_waddr = 5'd5; m_tnew = 2'd1;
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);
    // rt hazard from M, then E with tnew == tuse (no stall)
    idle(); d_rt = 5'd7; d_rt_tuse = 2'd0; m_waddr = 5'd7; m_tnew = 2'd1;
    expect_cycle(32'h0000_3004, 1'b1, 1'b0);
    idle(); d_rt = 5'd7; d_rt_tuse = 2'd1; e_waddr = 5'd7; e_tnew = 2'd1;
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);

    // 3. register 0 never stalls
    idle(); d_rs = 5'd0; e_waddr = 5'd0; e_tnew = 2'd2; d_rs_tuse = 2'd0;
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);

    // 4. mult then mflo: 6 stall cycles, then released
    idle(); d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0;
    expect_cycle(32'h0000_3004, 1'b1, 1'b1);
    e_md_start = 1'b0;
    for (int i = 0; i < 5; i++) expect_cycle(32'h0000_3004, 1'b1, 1'b1);
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);
    // div: 11 stall cycles
    e_md_start = 1'b1; e_md_div = 1'b1;
    expect_cycle(32'h0000_3004, 1'b1, 1'b1);
    e_md_start = 1'b0; e_md_div = 1'b0;
    for (int i = 0; i < 10; i++) expect_cycle(32'h0000_3004, 1'b1, 1'b1);
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);
    // busy without an md user does not stall; reload mid-count
    idle(); e_md_start = 1'b1;
    expect_cycle(32'h0000_3004, 1'b0, 1'b1);
    e_md_start = 1'b0;
    expect_cycle(32'h0000_3004, 1'b0, 1'b1);
    e_md_start = 1'b1;  // reload to 5 while counter is 4
    expect_cycle(32'h0000_3004, 1'b0, 1'b1);
    e_md_start = 1'b0;
    for (int i = 0; i < 5; i++) expect_cycle(32'h0000_3004, 1'b0, 1'b1);
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);

    // 5. next-PC selection
    idle(); npc_sel = 2'd1; d_pc = 32'h0000_3008; d_imm16 = 16'hFFFE; br_taken = 1'b1;
    f_pc = 32'h0000_300C;
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);
    br_taken = 1'b0;
    expect_cycle(32'h0000_3010, 1'b0, 1'b0);
    d_pc = 32'h0000_3000; d_imm16 = 16'h0010; br_taken = 1'b1;
    expect_cycle(32'h0000_3044, 1'b0, 1'b0);
    // target still computed while stalled
    d_rs = 5'd3; d_rs_tuse = 2'd0; e_waddr = 5'd3; e_tnew = 2'd1;
    expect_cycle(32'h0000_3044, 1'b1, 1'b0);
    idle(); npc_sel = 2'd2; d_pc = 32'h0000_3008; d_imm26 = 26'h0000C40;
    expect_cycle(32'h0000_3100, 1'b0, 1'b0);
    d_pc = 32'hF000_0000; d_imm26 = 26'h3FF_FFFF;
    expect_cycle(32'hFFFF_FFFC, 1'b0, 1'b0);
    idle(); npc_sel = 2'd3; d_rs_val = 32'h0000_3100;
    expect_cycle(32'h0000_3100, 1'b0, 1'b0);
    idle(); f_pc = 32'hFFFF_FFFC;
    expect_cycle(32'h0000_0000, 1'b0, 1'b0);

    // 6. reset mid-div with counter at 7
    idle(); e_md_start = 1'b1; e_md_div = 1'b1;
    expect_cycle(32'h0000_3004, 1'b0, 1'b1);
    e_md_start = 1'b0; e_md_div = 1'b0;
    for (int i = 0; i < 3; i++) expect_cycle(32'h0000_3004, 1'b0, 1'b1);
    reset = 1'b1; d_md_use = 1'b1;
    expect_cycle(32'h0000_3000, 1'b1, 1'b1);
    reset = 1'b0;
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);
    expect_cycle(32'h0000_3004, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
